// File: rtl/ledpattern_pkg.sv
// Mode encodings and brightness decay helper shared by the ledpattern engine.
package ledpattern_pkg;

    typedef enum logic [1:0] {
        LPM_BOUNCE  = 2'd0,
        LPM_SCAN    = 2'd1,
        LPM_BREATHE = 2'd2,
        LPM_STATIC  = 2'd3
    } lp_mode_e;

    // Trail decay: b - b/4 - 1, floored at zero (31,23,17,12,8,5,3,2,1,0 for 5 bits).
    function automatic int unsigned lp_decay(input int unsigned b);
        return (b > 1) ? (b - (b >> 2) - 1) : 0;
    endfunction

endpackage

// File: rtl/ledpwm_ch.sv
// One LED channel: brightness register (clear, load or decay/own step) and
// a registered PWM output bit compared against the shared bit-reversed phase.
module ledpwm_ch
    import ledpattern_pkg::*;
#(
    parameter int BW = 5
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          clr,
    input  logic          load,
    input  logic [BW-1:0] load_val,
    input  logic          step,
    input  logic          own,
    input  logic [BW-1:0] pwm,
    output logic          led
);

    localparam logic [BW-1:0] MAXB = '1;

    logic [BW-1:0] bright;
    logic [BW-1:0] b_dec;

    assign b_dec = BW'(lp_decay(32'(bright)));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bright <= '0;
            led    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (clr)
                bright <= '0;
            else if (load)
                bright <= load_val;
            else if (step)
                bright <= own ? MAXB : b_dec;

            if (bright == MAXB)
                led <= 1'b1;
            else if (bright == '0)
                led <= 1'b0;
            else
                led <= (pwm <= bright);
        end
    end

endmodule

// File: rtl/ledpattern.sv
// Multi-mode LED pattern engine: prescaler, owner/direction, breathe level and
// mode register, driving one ledpwm_ch per LED.
module ledpattern
    import ledpattern_pkg::*;
#(
    parameter int NLEDS   = 8,
    parameter int CTRBITS = 25,
    parameter int BW      = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [1:0]       i_mode,
    input  logic [NLEDS-1:0] i_static,
    input  logic             i_pause,
    output logic [1:0]       o_mode,
    output logic [NLEDS-1:0] o_leds
);

    // The counter is widened to BW bits when the prescaler is shorter, so the PWM phase keeps full resolution.
    localparam int                CW         = (CTRBITS > BW) ? CTRBITS : BW;
    localparam logic [BW-1:0]     MAXB       = '1;
    localparam logic [NLEDS-1:0]  OWNER_INIT = NLEDS'(1);

    lp_mode_e         mode_q;
    logic [CW-1:0]    ctr;
    logic             tick;
    logic [NLEDS-1:0] owner;
    logic             dir_up;
    logic [BW-1:0]    level;
    logic             lvl_down;

    logic [BW-1:0]    pwm;
    logic             owner_ok;
    logic             mode_chg;
    logic             step;
    logic             ch_load;
    logic             ch_decay;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pwm = '0;
        for (int i = 0; i < BW; i++)
            pwm[i] = ctr[BW-1-i];
        owner_ok = (owner != '0) && ((owner & (owner - OWNER_INIT)) == '0);
        mode_chg = tick && owner_ok && (lp_mode_e'(i_mode) != mode_q);
        step     = tick && owner_ok && !mode_chg;
        ch_load  = (mode_q == LPM_STATIC) || (mode_q == LPM_BREATHE);
        ch_decay = step && ((mode_q == LPM_BOUNCE) || (mode_q == LPM_SCAN));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctr      <= '0;
            tick     <= 1'b0;
            owner    <= OWNER_INIT;
            dir_up   <= 1'b1;
            level    <= '0;
            lvl_down <= 1'b0;
            mode_q   <= LPM_BOUNCE;
        end else begin
            if (i_pause) begin
                tick <= 1'b0;
            end else begin
                ctr  <= ctr + CW'(1);
                tick <= &ctr[CTRBITS-1:0];
            end

            // Owner recovery outranks both a pending mode change and the tick's step.
            if (!owner_ok) begin
                owner  <= OWNER_INIT;
                dir_up <= 1'b1;
            end else if (mode_chg) begin
                mode_q   <= lp_mode_e'(i_mode);
                owner    <= OWNER_INIT;
                dir_up   <= 1'b1;
                level    <= '0;
                lvl_down <= 1'b0;
            end else if (step) begin
                case (mode_q)
                    LPM_BOUNCE: begin
                        if (dir_up) begin
                            if (owner[NLEDS-1]) dir_up <= 1'b0;
                            else                owner  <= owner << 1;
                        end else begin
                            if (owner[0]) dir_up <= 1'b1;
                            else          owner  <= owner >> 1;
                        end
                    end
                    LPM_SCAN: begin
                        owner  <= {owner[NLEDS-2:0], owner[NLEDS-1]};
                        dir_up <= 1'b1;
                    end
                    LPM_BREATHE: begin
                        if (lvl_down) begin
                            level <= level - BW'(1);
                            if (level == BW'(1)) lvl_down <= 1'b0;
                        end else begin
                            level <= level + BW'(1);
                            if (level == MAXB - BW'(1)) lvl_down <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_mode = mode_q;

    for (genvar k = 0; k < NLEDS; k++) begin : g_ch
        logic [BW-1:0] load_val;

        assign load_val = (mode_q == LPM_STATIC) ? (i_static[k] ? MAXB : '0) : level;

        ledpwm_ch #(.BW(BW)) u_ch (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .clr       (mode_chg),
            .load      (ch_load),
            .load_val  (load_val),
            .step      (ch_decay),
            .own       (owner[k]),
            .pwm       (pwm),
            .led       (o_leds[k])
        );
    end

endmodule

// File: tb/tb_ledpattern.sv
// Scoreboard bench for ledpattern (NLEDS=4, CTRBITS=4, BW=5): stimulus queues
// cycle-stamped expectations, a monitor pops and compares them after each edge.
module tb_ledpattern;

    typedef enum int {K_LEDS, K_MODE, K_OWNER, K_TICK, K_LEVEL, K_B0} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] stat;
    logic       pause;
    logic [1:0] mode_out;
    logic [3:0] leds;

    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   r0;
    int   r1;
    exp_t sb[$];

    logic [3:0]  bounce_seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b1000,
                                    4'b0100, 4'b0010, 4'b0001, 4'b0001};
    logic [3:0]  scan_seq   [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                    4'b0010, 4'b0100, 4'b1000};
    // LED level for b=16 over the 16 phases cnt=18..31,0,1 (bit i = i-th cycle).
    logic [15:0] duty_vec = 16'hD555;

    ledpattern #(.NLEDS(4), .CTRBITS(4), .BW(5)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_mode    (mode),
        .i_static  (stat),
        .i_pause   (pause),
        .o_mode    (mode_out),
        .o_leds    (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int c, input kind_e k, input logic [31:0] v, input string name);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.exp  = v;
        e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [31:0] actual(input kind_e k);
        case (k)
            K_LEDS:  return 32'(leds);
            K_MODE:  return 32'(mode_out);
            K_OWNER: return 32'(dut.owner);
            K_TICK:  return 32'(dut.tick);
            K_LEVEL: return 32'(dut.level);
            default: return 32'(dut.g_ch[0].u_ch.bright);
        endcase
    endfunction

    // Monitor: sample 2 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check(e.name, actual(e.kind), e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        mode  = 2'd0;
        stat  = 4'b0000;
        pause = 1'b0;

        repeat (3) @(negedge clk);
        expect_at(cyc + 1, K_LEDS,  0, "reset_leds");
        expect_at(cyc + 1, K_MODE,  0, "reset_mode");
        expect_at(cyc + 1, K_OWNER, 1, "reset_owner");
        expect_at(cyc + 1, K_TICK,  0, "reset_tick");
        expect_at(cyc + 1, K_LEVEL, 0, "reset_level");
        @(negedge clk);
        rst_n = 1'b1;
        r0 = cyc;

        // BOUNCE: step k lands on edge r0+16k+1
        expect_at(r0 + 15, K_TICK, 0, "pre_first_tick");
        expect_at(r0 + 16, K_TICK, 1, "first_tick");
        for (int k = 1; k <= 8; k++)
            expect_at(r0 + 16*k + 8, K_OWNER, 32'(bounce_seq[k-1]), "bounce_owner");
        expect_at(r0 + 24, K_LEDS, 4'b0001, "bounce_leds_t1");
        expect_at(r0 + 40, K_LEDS, 4'b0010, "bounce_pwm_pwm28");
        expect_at(r0 + 41, K_LEDS, 4'b0011, "bounce_pwm_pwm2");
        expect_at(r0 + 40, K_B0, 23, "decay_23");
        expect_at(r0 + 56, K_B0, 17, "decay_17");

        // SCAN: mode change on step 9
        run_to(r0 + 130);
        mode = 2'd1;
        expect_at(r0 + 144, K_MODE, 0, "scan_pending");
        expect_at(r0 + 152, K_MODE, 1, "scan_mode");
        expect_at(r0 + 152, K_OWNER, 1, "scan_owner_reset");
        for (int k = 10; k <= 16; k++)
            expect_at(r0 + 16*k + 8, K_OWNER, 32'(scan_seq[k-10]), "scan_owner");
        expect_at(r0 + 168, K_LEDS, 4'b0001, "scan_leds");

        // BREATHE: mode change on step 17, level = k-17 up to 31
        run_to(r0 + 264);
        mode = 2'd2;
        expect_at(r0 + 280, K_MODE, 2, "breathe_mode");
        expect_at(r0 + 280, K_LEVEL, 0, "breathe_lvl0");
        expect_at(r0 + 296, K_LEVEL, 1, "breathe_lvl1");
        expect_at(r0 + 536, K_LEVEL, 16, "breathe_lvl16");
        expect_at(r0 + 776, K_LEVEL, 31, "breathe_lvl31");
        expect_at(r0 + 792, K_LEVEL, 30, "breathe_lvl30");
        for (int i = 0; i < 16; i++)
            expect_at(r0 + 531 + i, K_LEDS, duty_vec[i] ? 32'hF : 32'h0, "breathe_duty16");

        // STATIC: mode change on step 50 (edge r0+801)
        run_to(r0 + 792);
        mode = 2'd3;
        stat = 4'b1010;
        expect_at(r0 + 802, K_LEDS, 4'b0000, "static_cleared");
        expect_at(r0 + 803, K_LEDS, 4'b1010, "static_leds");
        expect_at(r0 + 803, K_MODE, 3, "static_mode");

        run_to(r0 + 810);
        pause = 1'b1;
        expect_at(r0 + 816, K_TICK, 0, "pause_no_tick_a");
        expect_at(r0 + 832, K_TICK, 0, "pause_no_tick_b");
        run_to(r0 + 820);
        stat = 4'b0101;
        expect_at(r0 + 821, K_LEDS, 4'b1010, "static_track_old");
        expect_at(r0 + 822, K_LEDS, 4'b0101, "static_track_new");

        run_to(r0 + 830);
        mode = 2'd0;
        run_to(r0 + 840);
        expect_at(r0 + 842, K_OWNER, 1, "owner_recover");
        force dut.owner = 4'b0000;
        run_to(r0 + 841);
        release dut.owner;
        expect_at(r0 + 900, K_MODE, 3, "pause_mode_pending");
        expect_at(r0 + 900, K_OWNER, 1, "pause_owner_hold");

        // Release: counter resumes at 10, tick after edge r0+926
        run_to(r0 + 920);
        pause = 1'b0;
        expect_at(r0 + 925, K_TICK, 0, "resume_pre_tick");
        expect_at(r0 + 926, K_TICK, 1, "resume_tick");
        expect_at(r0 + 926, K_MODE, 3, "resume_mode_old");
        expect_at(r0 + 927, K_MODE, 0, "resume_mode_new");
        expect_at(r0 + 950, K_OWNER, 4'b0010, "resume_bounce_step");

        run_to(r0 + 950);
        pause = 1'b1;
        expect_at(r0 + 958, K_TICK, 0, "pause2_no_tick");
        expect_at(r0 + 968, K_OWNER, 4'b0010, "pause2_owner_frozen");

        run_to(r0 + 970);
        pause = 1'b0;
        mode  = 2'd3;
        stat  = 4'b1111;
        expect_at(r0 + 984, K_MODE, 3, "prerst_mode");
        expect_at(r0 + 985, K_LEDS, 4'b1111, "prerst_leds");

        // Asynchronous reset asserted 1 time unit after edge r0+986
        run_to(r0 + 985);
        expect_at(r0 + 986, K_LEDS, 0, "async_rst_leds");
        expect_at(r0 + 986, K_MODE, 0, "async_rst_mode");
        expect_at(r0 + 986, K_OWNER, 1, "async_rst_owner");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mode  = 2'd0;
        run_to(r0 + 988);
        rst_n = 1'b1;
        r1 = cyc;
        expect_at(r1 + 15, K_TICK, 0, "rerun_pre_tick");
        expect_at(r1 + 16, K_TICK, 1, "rerun_first_tick");
        expect_at(r1 + 16, K_LEDS, 0, "rerun_leds");
        expect_at(r1 + 20, K_OWNER, 4'b0010, "rerun_first_step");

        run_to(r1 + 25);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            n_err++;
            $display("FAIL %s: got no sample, expected %0h at cycle %0d", e.name, e.exp, e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
